// File: rtl/ad2_sched_pkg.sv
// Shared types and sizing for the pmodAD2 channel scheduler.
package ad2_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_NEXT,
      S_CONFIG,
      S_DISCARD,
      S_SAMPLE
   } sched_state_t;

   localparam int CH_NUM             = 4;
   localparam int ADC_W              = 12;
   localparam int TIMEOUT_CYCLES_DEF = 1_000_000;

   // Width needed to count 0 .. max_count-1.
   function automatic int cnt_width(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count);
   endfunction

   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/rr_channel_pick.sv
// Round-robin search of the channel enable mask, starting one past the last visited channel.
module rr_channel_pick
   import ad2_sched_pkg::*;
(
   input  logic [CH_NUM-1:0] i_mask,
   input  logic [1:0]        i_last,
   output logic [1:0]        o_idx,
   output logic              o_found
);

   logic [1:0] w_cand;

   // Walk from farthest to nearest so the nearest enabled channel wins.
   always_comb begin
      o_idx   = i_last;
      o_found = 1'b0;
      w_cand  = i_last;
      for (int k = CH_NUM; k >= 1; k--) begin
         w_cand = i_last + 2'(k);
         if (i_mask[w_cand]) begin
            o_idx   = w_cand;
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ad2_channel_scheduler.sv
// Time-shares one pmodAD2 I2C controller across four inputs; capture-averaging is
// enabled by defining SAMPLE_AVG_EN (4-word average), otherwise single-word capture.
module ad2_channel_scheduler
   import ad2_sched_pkg::*;
#(
   parameter int RST_CYCLES     = 16,
   parameter int DISCARD_N      = 1,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [CH_NUM-1:0] ch_mask,
   input  logic [ADC_W-1:0]  adc_data,
   input  logic              adc_valid,
   output logic [CH_NUM-1:0] cfg_sel,
   output logic              ctrl_rst,
   output logic [ADC_W-1:0]  channel0,
   output logic [ADC_W-1:0]  channel1,
   output logic [ADC_W-1:0]  channel2,
   output logic [ADC_W-1:0]  channel3,
   output logic [CH_NUM-1:0] ch_valid,
   output logic [CH_NUM-1:0] timeout_err
);

   localparam int             TW        = cnt_width(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]  WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]     RST_LAST  = 8'(RST_CYCLES - 1);
   localparam logic [1:0]     DISC_INIT = 2'(DISCARD_N);

   sched_state_t      r_state;
   sched_state_t      w_state_nxt;
   logic [1:0]        r_idx;
   logic [CH_NUM-1:0] r_cfg_sel;
   logic [7:0]        r_rst_cnt;
   logic [1:0]        r_disc_cnt;
   logic [TW-1:0]     r_wait_cnt;
   logic [ADC_W-1:0]  r_ch [CH_NUM];
   logic [CH_NUM-1:0] r_ch_valid;
   logic [CH_NUM-1:0] r_timeout_err;

   logic [1:0]        w_pick_idx;
   logic              w_pick_found;
   logic              w_enter_wait;
   logic              w_enter_sample;
   logic              w_wait_expired;
   logic              w_timeout;
   logic              w_capture;
   logic              w_word;
   logic [ADC_W-1:0]  w_cap_data;

   rr_channel_pick u_pick (
      .i_mask  (ch_mask),
      .i_last  (r_idx),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

`ifdef SAMPLE_AVG_EN
   localparam int     ACC_W = ADC_W + 2;
   logic [ACC_W-1:0]  r_acc;
   logic [1:0]        r_avg_cnt;
   logic [ACC_W-1:0]  w_acc_sum;
   logic              w_last_word;

   assign w_acc_sum   = r_acc + {2'b00, adc_data};
   assign w_last_word = (r_avg_cnt == 2'd3);
   assign w_cap_data  = w_acc_sum[ACC_W-1:2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc     <= '0;
         r_avg_cnt <= '0;
      end else if (w_enter_sample) begin
         r_acc     <= '0;
         r_avg_cnt <= '0;
      end else if (w_word) begin
         r_acc     <= w_acc_sum;
         r_avg_cnt <= r_avg_cnt + 2'd1;
      end
   end
`else
   logic w_last_word;

   assign w_last_word = 1'b1;
   assign w_cap_data  = adc_data;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_enter_wait   = 1'b0;
      w_enter_sample = 1'b0;
      w_timeout      = 1'b0;
      w_capture      = 1'b0;
      w_word         = 1'b0;
      w_wait_expired = !adc_valid && (r_wait_cnt == WAIT_LAST);
      case (r_state)
         S_IDLE: w_state_nxt = S_NEXT;
         S_NEXT: w_state_nxt = w_pick_found ? S_CONFIG : S_IDLE;
         S_CONFIG: begin
            if (r_rst_cnt == 8'd0) begin
               w_enter_wait = 1'b1;
               if (DISCARD_N == 0) begin
                  w_enter_sample = 1'b1;
                  w_state_nxt    = S_SAMPLE;
               end else begin
                  w_state_nxt    = S_DISCARD;
               end
            end
         end
         S_DISCARD: begin
            if (adc_valid) begin
               if (r_disc_cnt == 2'd1) begin
                  w_enter_sample = 1'b1;
                  w_state_nxt    = S_SAMPLE;
               end
            end else if (w_wait_expired) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_NEXT;
            end
         end
         S_SAMPLE: begin
            if (adc_valid) begin
               w_word = 1'b1;
               if (w_last_word) begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_NEXT;
               end
            end else if (w_wait_expired) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_NEXT;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx         <= 2'd3;
         r_cfg_sel     <= '0;
         r_rst_cnt     <= '0;
         r_disc_cnt    <= '0;
         r_wait_cnt    <= '0;
         r_ch_valid    <= '0;
         r_timeout_err <= '0;
         for (int n = 0; n < CH_NUM; n++) r_ch[n] <= '0;
      end else begin
         r_ch_valid <= '0;
         // An empty mask clears the select so the idle controller sees no channel.
         if (r_state == S_NEXT) begin
            if (w_pick_found) begin
               r_idx     <= w_pick_idx;
               r_cfg_sel <= CH_NUM'(1) << w_pick_idx;
               r_rst_cnt <= RST_LAST;
            end else begin
               r_cfg_sel <= '0;
            end
         end else if (r_state == S_CONFIG && r_rst_cnt != 8'd0) begin
            r_rst_cnt <= r_rst_cnt - 8'd1;
         end

         if (w_enter_wait)
            r_disc_cnt <= DISC_INIT;
         else if (r_state == S_DISCARD && adc_valid)
            r_disc_cnt <= r_disc_cnt - 2'd1;

         if (w_enter_wait || w_enter_sample || adc_valid)
            r_wait_cnt <= '0;
         else if (r_state == S_DISCARD || r_state == S_SAMPLE)
            r_wait_cnt <= r_wait_cnt + TW'(1);

         if (w_timeout)
            r_timeout_err[r_idx] <= 1'b1;

         if (w_capture) begin
            r_ch[r_idx]          <= w_cap_data;
            r_ch_valid[r_idx]    <= 1'b1;
            r_timeout_err[r_idx] <= 1'b0;
         end
      end
   end

   // The controller is held in reset whenever no conversion is being awaited.
   assign ctrl_rst    = (r_state == S_IDLE) || (r_state == S_NEXT) || (r_state == S_CONFIG);
   assign cfg_sel     = r_cfg_sel;
   assign channel0    = r_ch[0];
   assign channel1    = r_ch[1];
   assign channel2    = r_ch[2];
   assign channel3    = r_ch[3];
   assign ch_valid    = r_ch_valid;
   assign timeout_err = r_timeout_err;

endmodule
